// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// registers the returned instruction with its PC for decode.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic              valid_n;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] if_pc_n;
    logic              halted_n;
    logic              misalign_n;
    logic [CNT_W-1:0]  count_n;
    logic [ADDR_W-1:0] target_aligned;
    logic              target_misaligned;

    assign imem_addr         = pc;
    assign target_aligned    = {redirect_target[ADDR_W-1:2], 2'b00};
    assign target_misaligned = (redirect_target[1:0] != 2'b00);

    // Next-state and next-value logic; every register holds by default.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        valid_n    = if_valid;
        instr_n    = if_instr;
        if_pc_n    = if_pc;
        halted_n   = halted;
        misalign_n = misalign_err;
        count_n    = fetch_count;
        unique case (state)
            BOOT: begin
                valid_n = 1'b0;
                state_n = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_n    = target_aligned;
                    valid_n = 1'b0;
                    if (target_misaligned) misalign_n = 1'b1;
                end else if (stall) begin
                    // hold everything
                end else if (imem_instr == 32'h0) begin
                    valid_n  = 1'b0;
                    halted_n = 1'b1;
                    state_n  = HALT;
                end else begin
                    instr_n = imem_instr;
                    if_pc_n = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + ADDR_W'(4);
                    count_n = fetch_count + CNT_W'(1);
                end
            end
            HALT: begin
                valid_n = 1'b0;
                if (redirect_valid) begin
                    pc_n     = target_aligned;
                    halted_n = 1'b0;
                    state_n  = RUN;
                    if (target_misaligned) misalign_n = 1'b1;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= '0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            if_valid     <= valid_n;
            if_instr     <= instr_n;
            if_pc        <= if_pc_n;
            halted       <= halted_n;
            misalign_err <= misalign_n;
            fetch_count  <= count_n;
        end
    end

endmodule
